pb_vernam_keystream: RTL and testbench
======================================

// Module: pb_vernam_keystream
// PURPOSE
// Parametrised keystream buffer and XOR engine sitting between the key-generator
// PicoBlaze (producer) and the cipher PicoBlaze (consumer). The producer pushes
// random key words into a FIFO. The consumer writes plaintext words through its
// port interface; the block XORs each one with the FIFO head and returns the
// ciphertext plus status through a registered, port_id-decoded input mux.
// PARAMETERS
// DATA_W   8   width of key, plaintext, ciphertext and port data
// DEPTH    16  keystream FIFO depth in words; power of two, >= 2
// CNT_W    $clog2(DEPTH+1)  occupancy counter width; derived, do not override
// PORTS
// clk            in   1       single system clock, all logic on rising edge
// reset_n        in   1       asynchronous, active-low reset
// key_wr         in   1       producer push strobe, one word per high cycle
// key_data       in   DATA_W  producer key word, sampled when key_wr=1
// key_full       out  1       FIFO full; producer must not push
// port_id        in   8       consumer port address
// write_strobe   in   1       consumer write strobe (one cycle)
// read_strobe    in   1       consumer read strobe (one cycle)
// out_port       in   DATA_W  consumer write data
// in_port        out  DATA_W  registered read data to consumer
// BEHAVIOUR
// - Reset (async, reset_n=0): FIFO empty, rd/wr pointers 0, count 0, result 0,
//   result_valid 0, sticky underflow/overflow 0, in_port 0, key_full 0.
// - FIFO: circular buffer, pointers wrap DEPTH-1 -> 0. count 0..DEPTH.
//   key_full = (count==DEPTH), combinational from registered count.
// - Push when full: word dropped, overflow flag set (sticky), count unchanged.
// - Consumer write map (write_strobe=1, decoded on port_id[7:6]):
//   00 ENCRYPT: if count>0, result <= out_port ^ fifo[rd_ptr], pop, result_valid<=1
//      on next edge. If count==0: result unchanged, no pop, underflow flag set.
//   01 FLUSH: pointers and count <= 0; flags and result untouched.
//   10 CLEAR: underflow, overflow, result_valid <= 0.
//   11 no effect.
// - Consumer read map, in_port <= mux(port_id[7:6]) every cycle (1-cycle latency,
//   within the two-cycle port_id window of the processor):
//   00 result word
//   01 status {.., overflow[3], underflow[2], result_valid[1], key_empty[0]}, zero-padded
//   10 count, zero-extended (truncated to DATA_W if CNT_W>DATA_W)
//   11 all zeros
// - read_strobe with port_id[7:6]==00 clears result_valid on the next edge;
//   status read does not clear flags (CLEAR write only).
// - Simultaneous push and ENCRYPT pop: both take effect, count unchanged,
//   even when full (push accepted, no overflow). When empty, pop underflows
//   and push is accepted; no bypass of the just-pushed word.
// - Simultaneous push and FLUSH: FLUSH wins, pushed word discarded, no overflow.
// - ENCRYPT with result_valid already 1: result overwritten, valid stays 1.
// - reset_n asserted mid-operation: immediate return to reset state; buffered
//   key words lost; no strobes honoured while reset_n=0.
// - All arithmetic unsigned, DATA_W wide, no carries; XOR only.
// TESTING
// 1 Reset: reset_n=0 mid-traffic -> in_port=0, status=0x01, count=0 immediately.
// 2 Push A5,3C; ENCRYPT FF,0F -> result reads 5A then 33, count 2->1->0, valid set.
// 3 DEPTH pushes then one more -> key_full=1, count=DEPTH, overflow bit3 set,
//   extra word absent: DEPTH ENCRYPT of 00 return pushed words in order.
// 4 ENCRYPT 77 on empty -> result unchanged, status bit2=1, count 0; CLEAR -> 0x01.
// 5 Full FIFO, push+ENCRYPT same cycle -> count stays DEPTH, no overflow,
//   pointers wrap; subsequent reads show correct order across wrap.
// 6 Push 3 words, FLUSH with concurrent push -> count 0, key_empty=1, next
//   ENCRYPT underflows.

Source files
------------

// File: rtl/pb_vernam_keystream_if.sv
// rtl/pb_vernam_keystream_if.sv - producer/consumer port bundle for the keystream XOR block
interface pb_vernam_keystream_if #(
   parameter int DATA_W = 8
);
   logic              key_wr;
   logic [DATA_W-1:0] key_data;
   logic              key_full;
   logic [7:0]        port_id;
   logic              write_strobe;
   logic              read_strobe;
   logic [DATA_W-1:0] out_port;
   logic [DATA_W-1:0] in_port;

   modport master (
      output key_wr, key_data, port_id, write_strobe, read_strobe, out_port,
      input  key_full, in_port
   );

   modport slave (
      input  key_wr, key_data, port_id, write_strobe, read_strobe, out_port,
      output key_full, in_port
   );
endinterface

// File: rtl/pb_vernam_keystream.sv
// rtl/pb_vernam_keystream.sv - keystream FIFO plus XOR engine between key-generator and cipher processors
module pb_vernam_keystream #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input logic                  i_clk,
   input logic                  i_reset_n,
   pb_vernam_keystream_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [1:0] SEL_ENCRYPT = 2'b00;
   localparam logic [1:0] SEL_FLUSH   = 2'b01;
   localparam logic [1:0] SEL_CLEAR   = 2'b10;
   localparam logic [1:0] SEL_RESULT  = 2'b00;
   localparam logic [1:0] SEL_STATUS  = 2'b01;
   localparam logic [1:0] SEL_COUNT   = 2'b10;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_in_port;
   logic              r_valid;
   logic              r_underflow;
   logic              r_overflow;

   logic [1:0]        w_sel;
   logic              w_empty;
   logic              w_full;
   logic              w_encrypt;
   logic              w_flush;
   logic              w_clear;
   logic              w_pop;
   logic              w_push;
   logic              w_overflow_evt;
   logic              w_underflow_evt;
   logic              w_result_rd;
   logic [DATA_W-1:0] w_status;
   logic [DATA_W-1:0] w_rd_mux;
   logic [5:0]        w_unused_port_bits;

   assign w_sel              = bus.port_id[7:6];
   assign w_unused_port_bits = bus.port_id[5:0];
   assign w_empty            = (r_count == '0);
   assign w_full             = (r_count == FULL_CNT);
   assign w_encrypt          = bus.write_strobe && (w_sel == SEL_ENCRYPT);
   assign w_flush            = bus.write_strobe && (w_sel == SEL_FLUSH);
   assign w_clear            = bus.write_strobe && (w_sel == SEL_CLEAR);
   assign w_result_rd        = bus.read_strobe && (w_sel == SEL_RESULT);
   assign w_pop              = w_encrypt && !w_empty;
   assign w_underflow_evt    = w_encrypt && w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push             = bus.key_wr && !w_flush && (!w_full || w_pop);
   assign w_overflow_evt     = bus.key_wr && !w_flush && w_full && !w_pop;

   assign bus.key_full = w_full;
   assign bus.in_port  = r_in_port;

   always_comb begin
      w_status      = '0;
      w_status[3:0] = {r_overflow, r_underflow, r_valid, w_empty};
   end

   always_comb begin
      w_rd_mux = '0;
      case (w_sel)
         SEL_RESULT: w_rd_mux = r_result;
         SEL_STATUS: w_rd_mux = w_status;
         SEL_COUNT:  w_rd_mux = DATA_W'(r_count);
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.key_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_result    <= '0;
         r_in_port   <= '0;
         r_valid     <= 1'b0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_in_port <= w_rd_mux;

         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
               r_count <= r_count - 1'b1;
            end
         end

         if (w_pop) begin
            r_result <= bus.out_port ^ r_mem[r_rd_ptr];
         end

         // New events take precedence over clears so no event is silently lost.
         if (w_pop) begin
            r_valid <= 1'b1;
         end else if (w_clear || w_result_rd) begin
            r_valid <= 1'b0;
         end

         if (w_underflow_evt) begin
            r_underflow <= 1'b1;
         end else if (w_clear) begin
            r_underflow <= 1'b0;
         end

         if (w_overflow_evt) begin
            r_overflow <= 1'b1;
         end else if (w_clear) begin
            r_overflow <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pb_vernam_keystream.sv
// tb/tb_pb_vernam_keystream.sv - scoreboard bench for the keystream FIFO and XOR engine
module tb_pb_vernam_keystream;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pb_vernam_keystream_if #(.DATA_W(DATA_W)) bus();

   pb_vernam_keystream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_q[$];
   logic [7:0] exp_q[$];
   logic       m_valid;
   logic       m_under;
   logic       m_over;
   logic [7:0] m_result;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.key_wr       = 1'b0;
      bus.key_data     = 8'h00;
      bus.write_strobe = 1'b0;
      bus.read_strobe  = 1'b0;
      bus.port_id      = 8'hC0;
      bus.out_port     = 8'h00;
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_valid  = 1'b0;
      m_under  = 1'b0;
      m_over   = 1'b0;
      m_result = 8'h00;
   endtask

   function automatic logic [7:0] exp_status();
      return {4'b0000, m_over, m_under, m_valid, (m_q.size() == 0)};
   endfunction

   // One clock of stimulus; the model is updated with the same cycle semantics as the design.
   task automatic drive(input bit push, input logic [7:0] key,
                        input bit wr, input logic [1:0] wsel, input logic [7:0] data);
      bit         pop;
      int         pre;
      logic [7:0] r;
      pop = 1'b0;
      pre = m_q.size();
      bus.key_wr       = push;
      bus.key_data     = key;
      bus.write_strobe = wr;
      bus.port_id      = {wsel, 6'h2A};
      bus.out_port     = data;
      if (wr && wsel == 2'b00) begin
         if (pre > 0) begin
            r = data ^ m_q.pop_front();
            m_result = r;
            m_valid  = 1'b1;
            exp_q.push_back(r);
            pop = 1'b1;
         end else begin
            m_under = 1'b1;
         end
      end
      if (wr && wsel == 2'b01) m_q.delete();
      if (push && !(wr && wsel == 2'b01)) begin
         if (pre < DEPTH || pop) m_q.push_back(key);
         else m_over = 1'b1;
      end
      if (wr && wsel == 2'b10) begin
         m_under = 1'b0;
         m_over  = 1'b0;
         m_valid = 1'b0;
      end
      tick();
      idle();
   endtask

   task automatic push(input logic [7:0] key);
      drive(1'b1, key, 1'b0, 2'b11, 8'h00);
   endtask

   task automatic encrypt(input logic [7:0] pt);
      drive(1'b0, 8'h00, 1'b1, 2'b00, pt);
   endtask

   task automatic clear_flags();
      drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h00);
   endtask

   task automatic rd(input logic [1:0] sel, input bit strobe, output logic [7:0] val);
      bus.port_id     = {sel, 6'h15};
      bus.read_strobe = strobe;
      tick();
      val = bus.in_port;
      idle();
      if (strobe && sel == 2'b00) m_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      idle();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.in_port !== 8'h00) begin failures++; $display("FAIL reset_in_port got %02h exp 00", bus.in_port); end
      checks++;
      if (bus.key_full !== 1'b0) begin failures++; $display("FAIL reset_key_full got %0b exp 0", bus.key_full); end
      reset_n = 1'b1;
      model_reset();
      rd(2'b01, 1'b0, v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL reset_status got %02h exp 01", v); end
      push(8'hA1);
      push(8'hB2);
      encrypt(8'h00);
      bus.port_id = 8'h80;
      tick();
      checks++;
      if (bus.in_port !== 8'h01) begin failures++; $display("FAIL pre_reset_count got %02h exp 01", bus.in_port); end
      bus.key_wr       = 1'b1;
      bus.key_data     = 8'hC3;
      bus.write_strobe = 1'b1;
      bus.port_id      = 8'h80;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.in_port !== 8'h00) begin failures++; $display("FAIL async_reset_in_port got %02h exp 00", bus.in_port); end
      tick();
      tick();
      idle();
      reset_n = 1'b1;
      model_reset();
      rd(2'b01, 1'b0, v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL post_reset_status got %02h exp 01", v); end
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL post_reset_count got %02h exp 00", v); end
      rd(2'b00, 1'b0, v);
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL post_reset_result got %02h exp 00", v); end
   endtask

   task automatic test_basic();
      logic [7:0] v;
      logic [7:0] e;
      push(8'hA5);
      push(8'h3C);
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'd2) begin failures++; $display("FAIL basic_count2 got %02h exp 02", v); end
      encrypt(8'hFF);
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e) begin failures++; $display("FAIL basic_status_valid got %02h exp %02h", v, e); end
      rd(2'b00, 1'b1, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      checks++;
      if (v !== e || e !== 8'h5A) begin failures++; $display("FAIL basic_result1 got %02h exp 5a", v); end
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'd1) begin failures++; $display("FAIL basic_count1 got %02h exp 01", v); end
      encrypt(8'h0F);
      rd(2'b00, 1'b1, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      checks++;
      if (v !== e || e !== 8'h33) begin failures++; $display("FAIL basic_result2 got %02h exp 33", v); end
      rd(2'b01, 1'b0, v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL basic_status_end got %02h exp 01", v); end
   endtask

   task automatic test_overflow();
      logic [7:0] v;
      logic [7:0] e;
      for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)));
      checks++;
      if (bus.key_full !== 1'b1) begin failures++; $display("FAIL ovf_key_full got %0b exp 1", bus.key_full); end
      push(8'hEE);
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e || v[3] !== 1'b1) begin failures++; $display("FAIL ovf_status got %02h exp %02h", v, e); end
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'(DEPTH)) begin failures++; $display("FAIL ovf_count got %02h exp %02h", v, 8'(DEPTH)); end
      for (int i = 0; i < DEPTH; i++) begin
         encrypt(8'h00);
         if (i == 0) begin
            checks++;
            if (bus.key_full !== 1'b0) begin failures++; $display("FAIL ovf_full_drop got %0b exp 0", bus.key_full); end
         end
         rd(2'b00, 1'b1, v);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : m_result;
         checks++;
         if (v !== e) begin failures++; $display("FAIL ovf_order[%0d] got %02h exp %02h", i, v, e); end
      end
      clear_flags();
      rd(2'b01, 1'b0, v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL ovf_clear got %02h exp 01", v); end
   endtask

   task automatic test_underflow();
      logic [7:0] v;
      logic [7:0] e;
      encrypt(8'h77);
      rd(2'b00, 1'b0, v);
      checks++;
      if (v !== m_result || exp_q.size() != 0) begin failures++; $display("FAIL unf_result got %02h exp %02h", v, m_result); end
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e || v[2] !== 1'b1) begin failures++; $display("FAIL unf_status got %02h exp %02h", v, e); end
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL unf_count got %02h exp 00", v); end
      clear_flags();
      rd(2'b01, 1'b0, v);
      checks++;
      if (v !== 8'h01) begin failures++; $display("FAIL unf_clear got %02h exp 01", v); end
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      logic [7:0] e;
      for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
      for (int i = 0; i < 5; i++) encrypt(8'h00);
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)));
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 2'b00, 8'($urandom_range(0, 255)));
         rd(2'b00, 1'b1, v);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : m_result;
         checks++;
         if (v !== e) begin failures++; $display("FAIL wrap_pe[%0d] got %02h exp %02h", i, v, e); end
      end
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'(DEPTH) || bus.key_full !== 1'b1) begin failures++; $display("FAIL wrap_count got %02h exp %02h", v, 8'(DEPTH)); end
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e || v[3] !== 1'b0) begin failures++; $display("FAIL wrap_status got %02h exp %02h", v, e); end
      for (int i = 0; i < DEPTH; i++) begin
         encrypt(8'($urandom_range(0, 255)));
         rd(2'b00, 1'b1, v);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : m_result;
         checks++;
         if (v !== e) begin failures++; $display("FAIL wrap_drain[%0d] got %02h exp %02h", i, v, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      logic [7:0] e;
      for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
      encrypt(8'h11);
      encrypt(8'h22);
      encrypt(8'h33);
      e = m_result;
      exp_q.delete();
      rd(2'b01, 1'b0, v);
      checks++;
      if (v[1] !== 1'b1 || v !== exp_status()) begin failures++; $display("FAIL b2b_status got %02h exp %02h", v, exp_status()); end
      rd(2'b00, 1'b1, v);
      checks++;
      if (v !== e) begin failures++; $display("FAIL b2b_last_result got %02h exp %02h", v, e); end
      encrypt(8'h44);
      rd(2'b00, 1'b1, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : m_result;
      checks++;
      if (v !== e) begin failures++; $display("FAIL b2b_drain got %02h exp %02h", v, e); end
   endtask

   task automatic test_flush();
      logic [7:0] v;
      logic [7:0] e;
      push(8'h10);
      push(8'h20);
      push(8'h30);
      drive(1'b1, 8'h99, 1'b1, 2'b01, 8'h00);
      rd(2'b10, 1'b0, v);
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL flush_count got %02h exp 00", v); end
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e || v[0] !== 1'b1 || v[3] !== 1'b0) begin failures++; $display("FAIL flush_status got %02h exp %02h", v, e); end
      encrypt(8'h00);
      rd(2'b01, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e || v[2] !== 1'b1) begin failures++; $display("FAIL flush_underflow got %02h exp %02h", v, e); end
      push(8'h5C);
      encrypt(8'h00);
      rd(2'b00, 1'b1, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : m_result;
      checks++;
      if (v !== e || e !== 8'h5C) begin failures++; $display("FAIL flush_next_word got %02h exp 5c", v); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_wrap();
      test_back_to_back();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
